// File: rtl/spi_fifo_pkg.sv
// Shared constants and helpers for the SPI TX/RX buffering FIFOs.
package spi_fifo_pkg;

   localparam int TX_WIDTH    = 32;
   localparam int TX_DEPTH    = 16;
   localparam int TX_AF_LEVEL = 12;
   localparam int TX_AE_LEVEL = 2;

   localparam int RX_WIDTH    = 32;
   localparam int RX_DEPTH    = 16;
   localparam int RX_AF_LEVEL = 12;
   localparam int RX_AE_LEVEL = 2;

   // Ceiling log2, used to size pointers at elaboration time.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/spi_param_fifo_if.sv
// Bus-side handshake and status bundle of the SPI parametrised FIFO.
interface spi_param_fifo_if
   import spi_fifo_pkg::*;
   #(parameter int WIDTH = TX_WIDTH,
     parameter int DEPTH = TX_DEPTH)
   ();

   localparam int AW = clog2(DEPTH);

   logic             Write;
   logic             Read;
   logic             Flush;
   logic             ClearOV;
   logic             ClearUF;
   logic [WIDTH-1:0] DataIn;
   logic [WIDTH-1:0] DataOut;
   logic             Full;
   logic             Empty;
   logic             AlmostFull;
   logic             AlmostEmpty;
   logic             OV;
   logic             UF;
   logic [AW:0]      Count;
   logic [AW-1:0]    ReadPtr;
   logic [AW-1:0]    WritePtr;

   modport master (
      output Write, Read, Flush, ClearOV, ClearUF, DataIn,
      input  DataOut, Full, Empty, AlmostFull, AlmostEmpty, OV, UF,
             Count, ReadPtr, WritePtr
   );

   modport slave (
      input  Write, Read, Flush, ClearOV, ClearUF, DataIn,
      output DataOut, Full, Empty, AlmostFull, AlmostEmpty, OV, UF,
             Count, ReadPtr, WritePtr
   );

endinterface

// File: rtl/spi_fifo_mem.sv
// FIFO storage: one write port and one registered read port, both on the falling edge.
module spi_fifo_mem
   import spi_fifo_pkg::*;
   #(parameter int WIDTH = TX_WIDTH,
     parameter int DEPTH = TX_DEPTH,
     localparam int AW  = clog2(DEPTH))
   (input  logic             Clock,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array carries no reset so it can map onto RAM; only the read register is reset.
   always_ff @(negedge Clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(negedge Clock or negedge Reset) begin
      if (!Reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/spi_param_fifo.sv
// Synchronous FIFO with same-edge read/write, thresholds, sticky OV/UF and flush.
module spi_param_fifo
   import spi_fifo_pkg::*;
   #(parameter int WIDTH    = TX_WIDTH,
     parameter int DEPTH    = TX_DEPTH,
     parameter int AF_LEVEL = TX_AF_LEVEL,
     parameter int AE_LEVEL = TX_AE_LEVEL)
   (input logic            Clock,
    input logic            Reset,
    spi_param_fifo_if.slave bus);

   localparam int AW = clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("spi_param_fifo: DEPTH must be a power of two and at least 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("spi_param_fifo: AF_LEVEL out of range");
   end
   if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("spi_param_fifo: AE_LEVEL out of range");
   end

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          ov, uf;
   logic          full, empty;
   logic          rd_ok, wr_ok, rd_en, wr_en;
   logic          set_ov, set_uf;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // Acceptance uses pre-edge occupancy; a read frees a slot for a same-edge write.
   assign rd_ok  = bus.Read & ~empty;
   assign wr_ok  = bus.Write & (~full | rd_ok);
   assign rd_en  = rd_ok & ~bus.Flush;
   assign wr_en  = wr_ok & ~bus.Flush;
   assign set_ov = bus.Write & ~wr_ok & ~bus.Flush;
   assign set_uf = bus.Read & ~rd_ok & ~bus.Flush;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(negedge Clock or negedge Reset) begin
      if (!Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.Flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A set event on the same edge outranks its clear.
   always_ff @(negedge Clock or negedge Reset) begin
      if (!Reset) begin
         ov <= 1'b0;
         uf <= 1'b0;
      end else begin
         if (set_ov)           ov <= 1'b1;
         else if (bus.ClearOV) ov <= 1'b0;
         if (set_uf)           uf <= 1'b1;
         else if (bus.ClearUF) uf <= 1'b0;
      end
   end

   spi_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .Clock   (Clock),
      .Reset   (Reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (bus.DataIn),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (bus.DataOut)
   );

   assign bus.Full        = full;
   assign bus.Empty       = empty;
   assign bus.AlmostFull  = (count >= (AW+1)'(AF_LEVEL));
   assign bus.AlmostEmpty = (count <= (AW+1)'(AE_LEVEL));
   assign bus.OV          = ov;
   assign bus.UF          = uf;
   assign bus.Count       = count;
   assign bus.ReadPtr     = rd_ptr;
   assign bus.WritePtr    = wr_ptr;

endmodule
